i2s_frame_sched: RTL and testbench

- Sequences serial DAC output from the divider's master-clock and frame strobes.
- Accepts stereo samples from the synth voice engine over a valid/ready handshake and double-buffers them.
- On every frame strobe, swaps the buffered sample into the shifter.
- Generates SCLK, LRCK and SDOUT (I2S format, MSB first, one-bit delay) for the audio codec PMOD.

---
 rtl/i2s_frame_sched_if.sv | 27 ++
 rtl/i2s_frame_sched.sv | 104 ++++++++++
 tb/tb_i2s_frame_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/i2s_frame_sched_if.sv
// i2s_frame_sched_if: strobe, sample handshake and serial output bundle for i2s_frame_sched
//   master: drives mclk_en, frame_en, in_valid, in_left, in_right; observes everything else
//   slave : the scheduler; drives in_ready, sclk, lrck, sdout, frame_start, underrun, resync
interface i2s_frame_sched_if #(
    parameter int WIDTH = 24
);
    logic             mclk_en;
    logic             frame_en;
    logic             in_valid;
    logic [WIDTH-1:0] in_left;
    logic [WIDTH-1:0] in_right;
    logic             in_ready;
    logic             sclk;
    logic             lrck;
    logic             sdout;
    logic             frame_start;
    logic             underrun;
    logic             resync;
    modport master (
        output mclk_en, frame_en, in_valid, in_left, in_right,
        input  in_ready, sclk, lrck, sdout, frame_start, underrun, resync
    );
    modport slave (
        input  mclk_en, frame_en, in_valid, in_left, in_right,
        output in_ready, sclk, lrck, sdout, frame_start, underrun, resync
    );
endinterface

// File: rtl/i2s_frame_sched.sv
// i2s_frame_sched: double-buffered I2S frame sequencer generating SCLK/LRCK/SDOUT from mclk/frame strobes
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of i2s_frame_sched_if
//              mclk_en/frame_en strobes in; in_valid/in_left/in_right/in_ready sample handshake;
//              sclk/lrck/sdout serial out; frame_start pulse; underrun/resync sticky flags
module i2s_frame_sched #(
    parameter int WIDTH  = 24,
    parameter int PH_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    i2s_frame_sched_if.slave bus
);
    localparam int PW = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;
    localparam logic [PW-1:0] PH_TOP = PW'(PH_MAX);
    localparam logic [PW-1:0] PH_MID = PW'(PH_MAX / 2);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state, state_n;
    logic [2*WIDTH-1:0] next_buf, next_buf_n, active, active_n;
    logic               next_full, next_full_n, in_ready, xfer;
    logic [PW-1:0]      ph, ph_n, ph_inc;
    logic [5:0]         b, b_n, b_inc;
    logic               sclk, sclk_n, lrck, lrck_n, sdout, sdout_n;
    logic               frame_start, underrun, underrun_n, resync, resync_n;
    logic [WIDTH-1:0]   word;
    logic [31:0]        slots;
    assign xfer = bus.in_valid && in_ready;
    assign bus.in_ready    = in_ready;
    assign bus.sclk        = sclk;
    assign bus.lrck        = lrck;
    assign bus.sdout       = sdout;
    assign bus.frame_start = frame_start;
    assign bus.underrun    = underrun;
    assign bus.resync      = resync;
    always_comb begin
        state_n     = state;
        ph_n        = ph;
        b_n         = b;
        sclk_n      = sclk;
        lrck_n      = lrck;
        sdout_n     = sdout;
        active_n    = active;
        underrun_n  = underrun;
        resync_n    = resync;
        // A full next buffer only empties on a frame load; in_ready is low then, so no transfer collides.
        next_full_n = (next_full && !bus.frame_en) || xfer;
        next_buf_n  = xfer ? {bus.in_left, bus.in_right} : next_buf;
        ph_inc      = (ph == PH_TOP) ? '0 : ph + 1'b1;
        b_inc       = b + 6'd1;
        word        = b_inc[5] ? active[WIDTH-1:0] : active[2*WIDTH-1:WIDTH];
        // 32 slots MSB-first: slot 0 is the one-bit I2S delay, then the word, then zero padding.
        slots       = 32'({1'b0, word}) << (31 - WIDTH);
        if (bus.frame_en) begin
            state_n    = RUN;
            active_n   = next_full ? next_buf : '0;
            underrun_n = underrun || !next_full;
            resync_n   = resync || (state == RUN && (b != 6'd63 || ph != PH_TOP));
            ph_n       = '0;
            b_n        = '0;
            sclk_n     = 1'b0;
            lrck_n     = 1'b0;
            sdout_n    = 1'b0;
        end else if (state == RUN && bus.mclk_en) begin
            ph_n   = ph_inc;
            sclk_n = ph_inc > PH_MID;
            if (ph == PH_TOP) begin
                b_n     = b_inc;
                lrck_n  = b_inc[5];
                sdout_n = slots[~b_inc[4:0]];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            next_buf    <= '0;
            next_full   <= 1'b0;
            active      <= '0;
            in_ready    <= 1'b0;
            ph          <= '0;
            b           <= '0;
            sclk        <= 1'b0;
            lrck        <= 1'b0;
            sdout       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            resync      <= 1'b0;
        end else begin
            state       <= state_n;
            next_buf    <= next_buf_n;
            next_full   <= next_full_n;
            active      <= active_n;
            in_ready    <= !next_full_n;
            ph          <= ph_n;
            b           <= b_n;
            sclk        <= sclk_n;
            lrck        <= lrck_n;
            sdout       <= sdout_n;
            frame_start <= bus.frame_en;
            underrun    <= underrun_n;
            resync      <= resync_n;
        end
    end
endmodule

// File: tb/tb_i2s_frame_sched.sv
// tb_i2s_frame_sched: directed self-checking bench for i2s_frame_sched
module tb_i2s_frame_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    i2s_frame_sched_if #(.WIDTH(24)) bus ();
    i2s_frame_sched #(.WIDTH(24), .PH_MAX(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rises, fs, rdy, xfers;
    logic [63:0] sd, lr;
    logic        any_out, prev_sclk = 1'b0;
    bit          auto_inc = 1'b0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic clr();
        rises = 0; fs = 0; rdy = 0; xfers = 0; sd = '0; lr = '0; any_out = 1'b0;
    endtask
    task automatic step();
        bit x;
        x = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (x) begin
            xfers++;
            if (auto_inc) begin
                bus.in_left  = bus.in_left + 24'd1;
                bus.in_right = bus.in_right + 24'd1;
            end
        end
        if (bus.sclk && !prev_sclk) begin
            rises++;
            sd = {sd[62:0], bus.sdout};
            lr = {lr[62:0], bus.lrck};
        end
        prev_sclk = bus.sclk;
        fs  += int'(bus.frame_start);
        rdy += int'(bus.in_ready);
        any_out = any_out | bus.sclk | bus.lrck | bus.sdout;
    endtask
    task automatic frame(input bit fe, input int len);
        clr();
        for (int k = 0; k < len; k++) begin
            bus.frame_en = fe && k == 0;
            bus.mclk_en  = (k % 4) == 0;
            step();
        end
        bus.frame_en = 1'b0;
        bus.mclk_en  = 1'b0;
    endtask
    function automatic logic [6:0] outs();
        return {bus.in_ready, bus.sclk, bus.lrck, bus.sdout, bus.frame_start, bus.underrun, bus.resync};
    endfunction
    initial begin
        bus.mclk_en = 1'b0; bus.frame_en = 1'b0; bus.in_valid = 1'b0;
        bus.in_left = '0; bus.in_right = '0;
        clr();
        // reset state
        repeat (3) step();
        check("reset_outputs", 64'(outs()), 64'h0);
        rst = 1'b0;
        step();
        check("ready_after_release", 64'(bus.in_ready), 64'h1);
        // idle: 100 mclk strobes, no frame_en
        frame(1'b0, 400);
        check("idle_outputs_quiet", 64'(any_out), 64'h0);
        check("idle_ready_held", 64'(rdy), 64'd400);
        // preload first sample
        bus.in_left = 24'hA5A5A5; bus.in_right = 24'h123456; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("ready_drops_after_xfer", 64'(bus.in_ready), 64'h0);
        // streaming with an incrementing source
        bus.in_left = 24'h100000; bus.in_right = 24'hF00001; bus.in_valid = 1'b1; auto_inc = 1'b1;
        frame(1'b1, 1024);
        check("f1_frame_start", 64'(fs), 64'd1);
        check("f1_sclk_rises", 64'(rises), 64'd64);
        check("f1_lrck", lr, 64'h00000000_FFFFFFFF);
        check("f1_sdout", sd, 64'h52D2D280_091A2B00);
        check("f1_xfers", 64'(xfers), 64'd1);
        check("f1_ready_cycles", 64'(rdy), 64'd1);
        frame(1'b1, 1024);
        check("f2_sdout", sd, 64'h08000000_78000080);
        check("f2_xfers", 64'(xfers), 64'd1);
        check("f2_ready_cycles", 64'(rdy), 64'd1);
        frame(1'b1, 1024);
        check("f3_sdout", sd, 64'h08000080_78000100);
        check("f3_flags", {62'd0, bus.underrun, bus.resync}, 64'h0);
        // withhold data for one frame
        bus.in_valid = 1'b0; auto_inc = 1'b0;
        frame(1'b1, 1024);
        check("f4_sdout", sd, 64'h08000100_78000180);
        check("f4_xfers", 64'(xfers), 64'd0);
        check("f4_no_underrun", 64'(bus.underrun), 64'h0);
        // frame_en coincident with a transfer into an empty buffer
        bus.in_left = 24'h7FFFFF; bus.in_right = 24'h800000; bus.in_valid = 1'b1;
        frame(1'b1, 1024);
        check("f5_sdout_zero", sd, 64'h0);
        check("f5_underrun", 64'(bus.underrun), 64'h1);
        check("f5_xfer_coincident", 64'(xfers), 64'd1);
        check("f5_frame_start", 64'(fs), 64'd1);
        frame(1'b1, 1024);
        check("f6_sdout", sd, 64'h3FFFFF80_40000000);
        check("f6_underrun_sticky", 64'(bus.underrun), 64'h1);
        check("f6_no_resync", 64'(bus.resync), 64'h0);
        // early frame_en at b=20
        frame(1'b1, 330);
        check("f7_no_resync_yet", 64'(bus.resync), 64'h0);
        frame(1'b1, 1024);
        check("f8_resync", 64'(bus.resync), 64'h1);
        check("f8_sclk_rises", 64'(rises), 64'd64);
        check("f8_sdout", sd, 64'h3FFFFF80_40000000);
        // reset mid-frame at b=40
        frame(1'b1, 648);
        check("f9_mid_frame_active", 64'(bus.lrck), 64'h1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midreset_outputs", 64'(outs()), 64'h0);
        rst = 1'b0;
        step();
        check("midreset_ready", 64'(bus.in_ready), 64'h1);
        frame(1'b0, 400);
        check("midreset_idle_quiet", 64'(any_out), 64'h0);
        frame(1'b1, 1024);
        check("post_reset_sdout_discarded", sd, 64'h0);
        check("post_reset_underrun", 64'(bus.underrun), 64'h1);
        check("post_reset_no_resync", 64'(bus.resync), 64'h0);
        check("post_reset_rises", 64'(rises), 64'd64);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
